// File: rtl/alu_issue_if.sv
// ============================================================================
// Module      : alu_issue_if
// Description : Instruction handshake, ALU drive/return and debug read bundle
//               for alu_issue_ctrl. Names are from the controller's viewpoint.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             i_in_valid;
    logic             o_in_ready;
    logic [31:0]      i_instr;
    logic [WIDTH-1:0] o_alu_in1;
    logic [WIDTH-1:0] o_alu_in2;
    logic [3:0]       o_alu_opcode;
    logic [3:0]       o_alu_cond;
    logic             o_alu_s;
    logic [2:0]       o_alu_sr_cont;
    logic [4:0]       o_alu_sr_bit;
    logic [15:0]      o_alu_imm;
    logic [WIDTH-1:0] i_alu_out;
    logic [3:0]       i_alu_flags;
    logic             i_alu_cond_met;
    logic             o_done;
    logic             o_executed;
    logic [WIDTH-1:0] o_result;
    logic [3:0]       o_flags_out;
    logic [3:0]       i_dbg_addr;
    logic [WIDTH-1:0] o_dbg_data;

    // Controller side
    modport slave (
        input  i_in_valid, i_instr, i_alu_out, i_alu_flags, i_alu_cond_met, i_dbg_addr,
        output o_in_ready, o_alu_in1, o_alu_in2, o_alu_opcode, o_alu_cond, o_alu_s,
               o_alu_sr_cont, o_alu_sr_bit, o_alu_imm, o_done, o_executed, o_result,
               o_flags_out, o_dbg_data
    );

    // Fetch stage / ALU / debug side
    modport master (
        output i_in_valid, i_instr, i_alu_out, i_alu_flags, i_alu_cond_met, i_dbg_addr,
        input  o_in_ready, o_alu_in1, o_alu_in2, o_alu_opcode, o_alu_cond, o_alu_s,
               o_alu_sr_cont, o_alu_sr_bit, o_alu_imm, o_done, o_executed, o_result,
               o_flags_out, o_dbg_data
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Non-pipelined ALU issue controller: IDLE -> EXEC -> WB, with a
//               16x32 register file and architectural flags register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int NREGS = 16,
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_issue_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [3:0] c_OP_CMP = 4'b1011;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] r_res_hold;
    logic [3:0]       r_flags_hold;
    logic             r_met_hold;

    logic             w_in_idle;
    logic             w_in_exec;
    logic             w_in_wb;
    logic             w_accept;
    logic             w_wr_en;
    logic             w_flag_en;
    logic [3:0]       w_op;
    logic [3:0]       w_rd;
    logic [3:0]       w_rn;
    logic [3:0]       w_rm;

    assign w_op = r_ir[27:24];
    assign w_rd = r_ir[22:19];
    assign w_rn = r_ir[18:15];
    assign w_rm = r_ir[14:11];

    assign w_in_idle = (r_state == S_IDLE);
    assign w_in_exec = (r_state == S_EXEC);
    assign w_in_wb   = (r_state == S_WB);
    assign w_accept  = w_in_idle & bus.i_in_valid;

    // Only ops 0000..0111 produce a register result; CMP additionally updates flags.
    assign w_wr_en   = w_in_wb & r_met_hold & ~w_op[3];
    assign w_flag_en = w_in_wb & r_met_hold & (r_ir[23] | (w_op == c_OP_CMP));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_in_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ir         <= '0;
            r_flags      <= '0;
            r_res_hold   <= '0;
            r_flags_hold <= '0;
            r_met_hold   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ir <= bus.i_instr;
            end
            if (w_in_exec) begin
                r_res_hold   <= bus.i_alu_out;
                r_flags_hold <= bus.i_alu_flags;
                r_met_hold   <= bus.i_alu_cond_met;
            end
            if (w_wr_en) begin
                r_regs[w_rd] <= r_res_hold;
            end
            if (w_flag_en) begin
                r_flags <= r_flags_hold;
            end
        end
    end

    // ALU drive is forced to zero outside EXEC so the ALU sees a quiet bus.
    assign bus.o_in_ready    = w_in_idle;
    assign bus.o_alu_in1     = w_in_exec ? r_regs[w_rn] : '0;
    assign bus.o_alu_in2     = w_in_exec ? r_regs[w_rm] : '0;
    assign bus.o_alu_opcode  = w_in_exec ? w_op         : '0;
    assign bus.o_alu_cond    = w_in_exec ? r_ir[31:28]  : '0;
    assign bus.o_alu_s       = w_in_exec & r_ir[23];
    assign bus.o_alu_sr_cont = w_in_exec ? r_ir[10:8]   : '0;
    assign bus.o_alu_sr_bit  = w_in_exec ? r_ir[7:3]    : '0;
    assign bus.o_alu_imm     = w_in_exec ? r_ir[15:0]   : '0;

    assign bus.o_done        = w_in_wb;
    assign bus.o_executed    = w_in_wb & r_met_hold;
    assign bus.o_result      = (w_in_wb & r_met_hold) ? r_res_hold : '0;
    assign bus.o_flags_out   = r_flags;
    assign bus.o_dbg_data    = r_regs[bus.i_dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl with a small
//               combinational ALU model on the return path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [31:0] cap_in1;
    logic [31:0] cap_in2;
    logic [3:0]  cap_op;
    logic [2:0]  cap_src;
    logic [4:0]  cap_srb;

    logic [31:0] m_sh;
    logic [31:0] m_res;

    alu_issue_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(.NREGS(16), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: 0000 ADD, 0110 MOVI, 1011 CMP (subtract); SrCont 2 = shift left.
    // Flags {N,Z,C,V} with C/V tied low; cond 0 = always, 1 = EQ on current flags.
    always_comb begin
        m_sh  = (bus.o_alu_sr_cont == 3'd2) ? (bus.o_alu_in2 << bus.o_alu_sr_bit) : bus.o_alu_in2;
        m_res = 32'd0;
        case (bus.o_alu_opcode)
            4'b0000: m_res = bus.o_alu_in1 + m_sh;
            4'b0110: m_res = {16'd0, bus.o_alu_imm};
            4'b1011: m_res = bus.o_alu_in1 - m_sh;
            default: m_res = 32'd0;
        endcase
        bus.i_alu_out      = m_res;
        bus.i_alu_flags    = {m_res[31], (m_res == 32'd0), 2'b00};
        bus.i_alu_cond_met = (bus.o_alu_cond == 4'd0) ? 1'b1 :
                             (bus.o_alu_cond == 4'd1) ? bus.o_flags_out[2] : 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                       input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                                       input logic [2:0] src, input logic [4:0] srb);
        return {cond, op, s, rd, rn, rm, src, srb, 3'b000};
    endfunction

    function automatic logic [31:0] movi(input logic [3:0] rd, input logic [15:0] imm);
        return {4'd0, 4'b0110, 1'b0, rd, 3'b000, imm};
    endfunction

    task automatic reg_check(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        bus.i_dbg_addr = idx;
        #1;
        check_val(tag, bus.o_dbg_data, exp);
    endtask

    // Returns one time unit after the accepting edge, i.e. inside EXEC.
    task automatic issue(input logic [31:0] w);
        int n = 0;
        while (!bus.o_in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("issue_ready", {31'd0, bus.o_in_ready}, 32'd1);
        bus.i_instr    = w;
        bus.i_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_in_valid = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [31:0] w,
                             input logic exp_met, input logic [31:0] exp_res);
        issue(w);
        @(negedge clk);
        cap_in1 = bus.o_alu_in1;
        cap_in2 = bus.o_alu_in2;
        cap_op  = bus.o_alu_opcode;
        cap_src = bus.o_alu_sr_cont;
        cap_srb = bus.o_alu_sr_bit;
        check_val({tag, "_exec_done"}, {31'd0, bus.o_done}, 32'd0);
        @(negedge clk);
        check_val({tag, "_done"}, {31'd0, bus.o_done}, 32'd1);
        check_val({tag, "_executed"}, {31'd0, bus.o_executed}, {31'd0, exp_met});
        check_val({tag, "_result"}, bus.o_result, exp_res);
        @(negedge clk);
        check_val({tag, "_idle_ready"}, {31'd0, bus.o_in_ready}, 32'd1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.i_in_valid = 1'b0;
        bus.i_instr    = 32'd0;
        bus.i_dbg_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        check_val("rst_ready", {31'd0, bus.o_in_ready}, 32'd1);
        check_val("rst_done", {31'd0, bus.o_done}, 32'd0);
        check_val("rst_flags", {28'd0, bus.o_flags_out}, 32'd0);
        check_val("rst_alu_in1", bus.o_alu_in1, 32'd0);
        reg_check("rst_r1", 4'd1, 32'd0);

        // MOVI / MOVI / ADD
        run_instr("movi_r1", movi(4'd1, 16'd5), 1'b1, 32'd5);
        run_instr("movi_r2", movi(4'd2, 16'd7), 1'b1, 32'd7);
        run_instr("add_r3", mk(4'd0, 4'b0000, 1'b0, 4'd3, 4'd1, 4'd2, 3'd0, 5'd0), 1'b1, 32'd12);
        check_val("add_r3_in1", cap_in1, 32'd5);
        check_val("add_r3_in2", cap_in2, 32'd7);
        reg_check("r3", 4'd3, 32'd12);

        // InValid held high: ready 1,0,0 and done 0,0,1 repeating; operands only in EXEC
        bus.i_instr    = mk(4'd0, 4'b0000, 1'b0, 4'd7, 4'd1, 4'd2, 3'd0, 5'd0);
        bus.i_in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check_val($sformatf("stream_ready_%0d", i), {31'd0, bus.o_in_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("stream_done_%0d", i), {31'd0, bus.o_done}, (i % 3 == 2) ? 32'd1 : 32'd0);
            check_val($sformatf("stream_in1_%0d", i), bus.o_alu_in1, (i % 3 == 1) ? 32'd5 : 32'd0);
            if (i == 8) bus.i_in_valid = 1'b0;
            @(negedge clk);
        end
        check_val("stream_idle", {31'd0, bus.o_in_ready}, 32'd1);
        reg_check("r7", 4'd7, 32'd12);

        // EQ with Z clear: not executed, nothing written
        run_instr("add_eq", mk(4'd1, 4'b0000, 1'b0, 4'd4, 4'd1, 4'd2, 3'd0, 5'd0), 1'b0, 32'd0);
        reg_check("r4", 4'd4, 32'd0);
        check_val("eq_flags", {28'd0, bus.o_flags_out}, 32'd0);

        // Shifted operand: 5 + (1 << 4)
        run_instr("movi_r2b", movi(4'd2, 16'd1), 1'b1, 32'd1);
        run_instr("add_sh", mk(4'd0, 4'b0000, 1'b0, 4'd5, 4'd1, 4'd2, 3'd2, 5'd4), 1'b1, 32'd21);
        check_val("sh_cont", {29'd0, cap_src}, 32'd2);
        check_val("sh_bit", {27'd0, cap_srb}, 32'd4);
        reg_check("r5", 4'd5, 32'd21);

        // CMP updates flags only; later S=0 ADD leaves them; S=1 ADD rewrites them
        run_instr("cmp", mk(4'd0, 4'b1011, 1'b0, 4'd8, 4'd1, 4'd1, 3'd0, 5'd0), 1'b1, 32'd0);
        check_val("cmp_op", {28'd0, cap_op}, 32'd11);
        reg_check("r8", 4'd8, 32'd0);
        check_val("cmp_flags", {28'd0, bus.o_flags_out}, 32'h4);
        run_instr("add_s0", mk(4'd0, 4'b0000, 1'b0, 4'd9, 4'd1, 4'd2, 3'd0, 5'd0), 1'b1, 32'd6);
        check_val("s0_flags", {28'd0, bus.o_flags_out}, 32'h4);
        reg_check("r9", 4'd9, 32'd6);
        run_instr("add_eq_met", mk(4'd1, 4'b0000, 1'b0, 4'd10, 4'd1, 4'd1, 3'd0, 5'd0), 1'b1, 32'd10);
        reg_check("r10", 4'd10, 32'd10);
        run_instr("add_s1", mk(4'd0, 4'b0000, 1'b1, 4'd11, 4'd1, 4'd2, 3'd0, 5'd0), 1'b1, 32'd6);
        check_val("s1_flags", {28'd0, bus.o_flags_out}, 32'h0);

        // Reset during EXEC aborts the instruction and clears all state
        issue(mk(4'd0, 4'b0000, 1'b1, 4'd6, 4'd1, 4'd2, 3'd0, 5'd0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort_ready", {31'd0, bus.o_in_ready}, 32'd1);
        check_val("abort_done", {31'd0, bus.o_done}, 32'd0);
        check_val("abort_flags", {28'd0, bus.o_flags_out}, 32'd0);
        @(negedge clk);
        check_val("abort_done2", {31'd0, bus.o_done}, 32'd0);
        for (int r = 0; r < 16; r++) begin
            reg_check($sformatf("abort_r%0d", r), r[3:0], 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
